uart_tx_feeder: RTL and testbench

Byte-buffering stage directly upstream of the UART transmitter. It accepts bytes from the system side (register file / controller) into a small synchronous FIFO. It then issues them one at a time to the transmitter as a single-cycle DATA_VALID pulse with stable P_DATA, pacing issue on the transmitter's BUSY output. A watchdog catches a transmitter that never acknowledges.

---
 rtl/uart_tx_feeder.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: one-cycle DATA_VALID strobes paced on the
// transmitter's BUSY, with a watchdog for a transmitter that never acknowledges.
module uart_tx_feeder #(
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic [7:0]        WR_DATA,
    output logic              FULL,
    output logic              EMPTY,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW,
    input  logic              TX_BUSY,
    output logic              TX_DATA_VALID,
    output logic [7:0]        TX_P_DATA,
    output logic              ACK_ERR
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int WD_W  = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Last watchdog value before the timeout edge; the pulse lands ACK_TIMEOUT-1 cycles after the strobe.
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(ACK_TIMEOUT - 2);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [7:0]         mem_r [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_r;
    logic [ADDR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic               full_r;
    logic               empty_r;
    logic               overflow_r;
    logic               tx_valid_r;
    logic [7:0]         tx_data_r;
    logic               ack_err_r;
    logic               ack_err_next_s;
    logic [WD_W-1:0]    wd_r;
    logic [WD_W-1:0]    wd_next_s;
    logic               issue_s;
    logic               push_s;

    assign FULL          = full_r;
    assign EMPTY         = empty_r;
    assign COUNT         = count_r;
    assign OVERFLOW      = overflow_r;
    assign TX_DATA_VALID = tx_valid_r;
    assign TX_P_DATA     = tx_data_r;
    assign ACK_ERR       = ack_err_r;

    // Push acceptance and next occupancy; FULL is judged on the pre-edge count.
    always_comb begin
        push_s       = 1'b0;
        count_next_s = count_r;
        if (WR_EN && !full_r) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        case ({push_s, issue_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Issue FSM: next state, issue decision, watchdog and timeout pulse.
    always_comb begin
        state_next_s   = state_r;
        issue_s        = 1'b0;
        wd_next_s      = wd_r;
        ack_err_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_r && !TX_BUSY) begin
                    issue_s      = 1'b1;
                    wd_next_s    = '0;
                    state_next_s = WAIT_ACK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_ACK: begin
                if (TX_BUSY) begin
                    state_next_s = WAIT_DONE;
                end else if (wd_r == WD_LAST) begin
                    wd_next_s      = wd_r + WD_ONE;
                    ack_err_next_s = 1'b1;
                    state_next_s   = IDLE;
                end else begin
                    wd_next_s    = wd_r + WD_ONE;
                    state_next_s = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control, pointer, occupancy and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            ack_err_r  <= 1'b0;
            wd_r       <= '0;
        end else begin
            state_r    <= state_next_s;
            wd_r       <= wd_next_s;
            tx_valid_r <= issue_s;
            ack_err_r  <= ack_err_next_s;
            count_r    <= count_next_s;
            full_r     <= (count_next_s == CNT_FULL);
            empty_r    <= (count_next_s == '0);
            if (issue_s) begin
                tx_data_r <= mem_r[rd_ptr_r];
                rd_ptr_r  <= rd_ptr_r + PTR_ONE;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (WR_EN && full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are meaningless once the pointers reset, so no reset here.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= WR_DATA;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder: a queue-based reference model predicts every
// output each cycle while a small transmitter model drives TX_BUSY.
module tb_uart_tx_feeder;

    localparam int DEPTH       = 8;
    localparam int ADDR_W      = 3;
    localparam int ACK_TIMEOUT = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic              WR_EN;
    logic [7:0]        WR_DATA;
    logic              FULL;
    logic              EMPTY;
    logic [ADDR_W:0]   COUNT;
    logic              OVERFLOW;
    logic              TX_BUSY;
    logic              TX_DATA_VALID;
    logic [7:0]        TX_P_DATA;
    logic              ACK_ERR;

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
        .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
        .TX_BUSY(TX_BUSY), .TX_DATA_VALID(TX_DATA_VALID), .TX_P_DATA(TX_P_DATA),
        .ACK_ERR(ACK_ERR)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int strobes = 0;
    int ack_cyc = -1;
    logic [7:0] issued_q[$];
    int         issued_cyc[$];

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_free = 1'b1;
    bit         m_acked = 1'b0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         e_valid = 1'b0;
    bit         e_ack = 1'b0;
    int         m_age = 0;

    // Transmitter model: 0 responds, 1 mute, 2 busy held high
    int tx_mode = 0;
    int tx_left = 0;
    int fixed_len = 0;
    bit tx_arm = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int  sz;
        bit  pre_full;
        if (RST) begin
            m_q.delete();
            m_free = 1'b1; m_acked = 1'b0; m_ovf = 1'b0; m_data = 8'h00;
            e_valid = 1'b0; e_ack = 1'b0; m_age = 0;
        end else begin
            sz = m_q.size();
            pre_full = (sz == DEPTH);
            e_valid = 1'b0;
            e_ack = 1'b0;
            if (m_free) begin
                if (sz > 0 && !TX_BUSY) begin
                    m_data = m_q.pop_front();
                    e_valid = 1'b1; m_free = 1'b0; m_acked = 1'b0; m_age = 0;
                end
            end else if (m_acked) begin
                if (!TX_BUSY) m_free = 1'b1;
            end else if (TX_BUSY) begin
                m_acked = 1'b1;
            end else begin
                m_age++;
                if (m_age == ACK_TIMEOUT - 1) begin
                    e_ack = 1'b1;
                    m_free = 1'b1;
                end
            end
            if (WR_EN) begin
                if (pre_full) m_ovf = 1'b1;
                else m_q.push_back(WR_DATA);
            end
        end
    endtask

    task automatic step();
        logic [31:0] got;
        logic [31:0] exp;
        int sz;
        @(posedge CLK);
        model_edge();
        #1;
        cyc++;
        sz  = m_q.size();
        got = {15'd0, OVERFLOW, FULL, EMPTY, COUNT, ACK_ERR, TX_DATA_VALID, TX_P_DATA};
        exp = {15'd0, m_ovf, (sz == DEPTH), (sz == 0), 4'(sz), e_ack, e_valid, m_data};
        check_val("cycle", got, exp);
        if (TX_DATA_VALID === 1'b1) begin
            strobes++;
            issued_q.push_back(TX_P_DATA);
            issued_cyc.push_back(cyc);
        end
        if (ACK_ERR === 1'b1) ack_cyc = cyc;
        if (tx_arm) begin
            tx_left = (fixed_len > 0) ? fixed_len : int'($urandom_range(8, 2));
            tx_arm = 1'b0;
        end
        if (TX_DATA_VALID === 1'b1 && tx_mode == 0) tx_arm = 1'b1;
        TX_BUSY = (tx_mode == 2) ? 1'b1 : (tx_left > 0);
        if (tx_left > 0) tx_left--;
        if (TX_DATA_VALID === 1'b1) check_val("strobe_busy", 32'(TX_BUSY), 32'd0);
        WR_EN = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        WR_EN = 1'b1;
        WR_DATA = d;
        step();
    endtask

    initial begin
        logic [7:0] exp3[4];
        logic [7:0] acc[$];
        int s0;
        int n0;
        int g;
        RST = 1'b1; WR_EN = 1'b0; WR_DATA = 8'h00; TX_BUSY = 1'b0;

        // 1: reset then idle
        step(); step();
        RST = 1'b0;
        step();
        check_val("rst_empty", 32'(EMPTY), 32'd1);
        check_val("rst_count", 32'(COUNT), 32'd0);
        check_val("rst_valid", 32'(TX_DATA_VALID), 32'd0);
        check_val("rst_pdata", 32'(TX_P_DATA), 32'h00);
        s0 = strobes;
        repeat (20) step();
        check_val("idle_strobes", 32'(strobes - s0), 32'd0);

        // 2: single byte, long frame
        fixed_len = 110;
        s0 = strobes; n0 = issued_q.size();
        push_byte(8'hA5);
        repeat (130) step();
        check_val("single_strobes", 32'(strobes - s0), 32'd1);
        check_val("single_data", (issued_q.size() > n0) ? 32'(issued_q[n0]) : 32'hdead, 32'hA5);
        check_val("single_count", 32'(COUNT), 32'd0);

        // 3: paced burst
        fixed_len = 0;
        exp3 = '{8'h55, 8'hAA, 8'h0F, 8'hF0};
        n0 = issued_q.size();
        for (int i = 0; i < 4; i++) push_byte(exp3[i]);
        repeat (80) step();
        check_val("burst_n", 32'(issued_q.size() - n0), 32'd4);
        for (int i = 0; i < 4; i++)
            check_val("burst_data", (issued_q.size() > n0 + i) ? 32'(issued_q[n0 + i]) : 32'hdead, 32'(exp3[i]));

        // 4: full, overflow, pointer wrap
        tx_mode = 2;
        step();
        n0 = issued_q.size();
        for (int i = 0; i < 9; i++) begin
            push_byte(8'h10 + 8'(i));
            if (i < 8) acc.push_back(8'h10 + 8'(i));
            if (i == 7) check_val("full8", 32'(FULL), 32'd1);
        end
        check_val("ovf9", 32'(OVERFLOW), 32'd1);
        check_val("count9", 32'(COUNT), 32'd8);
        tx_mode = 0;
        for (int k = 0; k < 8; k++) begin
            g = 0;
            while (m_q.size() >= DEPTH && g < 500) begin step(); g++; end
            push_byte(8'h80 + 8'(k));
            acc.push_back(8'h80 + 8'(k));
        end
        repeat (260) step();
        check_val("wrap_n", 32'(issued_q.size() - n0), 32'd16);
        for (int i = 0; i < 16; i++)
            check_val("wrap_data", (issued_q.size() > n0 + i) ? 32'(issued_q[n0 + i]) : 32'hdead, 32'(acc[i]));

        // 5: acknowledge timeout
        tx_mode = 1;
        ack_cyc = -1;
        n0 = issued_q.size();
        push_byte(8'h3C);
        push_byte(8'h77);
        g = 0;
        while (ack_cyc < 0 && g < 60) begin step(); g++; end
        tx_mode = 0;
        check_val("ack_seen", 32'(ack_cyc >= 0), 32'd1);
        check_val("ack_data", (issued_q.size() > n0) ? 32'(issued_q[n0]) : 32'hdead, 32'h3C);
        check_val("ack_delay", (issued_cyc.size() > n0) ? 32'(ack_cyc - issued_cyc[n0]) : 32'hdead,
                  32'(ACK_TIMEOUT - 1));
        repeat (30) step();
        check_val("after_ack_n", 32'(issued_q.size() - n0), 32'd2);
        check_val("after_ack_data", (issued_q.size() > n0 + 1) ? 32'(issued_q[n0 + 1]) : 32'hdead, 32'h77);
        check_val("after_ack_gap", (issued_cyc.size() > n0 + 1) ? 32'(issued_cyc[n0 + 1] - ack_cyc) : 32'hdead,
                  32'd1);

        // 6: reset during WAIT_DONE
        fixed_len = 20;
        s0 = strobes;
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
        g = 0;
        while (strobes == s0 && g < 40) begin step(); g++; end
        repeat (5) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_val("mid_rst_count", 32'(COUNT), 32'd0);
        check_val("mid_rst_empty", 32'(EMPTY), 32'd1);
        check_val("mid_rst_ovf", 32'(OVERFLOW), 32'd0);
        s0 = strobes;
        repeat (40) step();
        check_val("mid_rst_strobes", 32'(strobes - s0), 32'd0);

        // 7: random traffic with occasional mute transmitter
        fixed_len = 0;
        for (int b = 0; b < 10; b++) begin
            tx_mode = ($urandom % 4 == 0) ? 1 : 0;
            repeat (50) begin
                WR_EN = ($urandom % 3 == 0);
                WR_DATA = 8'($urandom);
                step();
            end
        end
        tx_mode = 0;
        repeat (200) step();
        check_val("drain_count", 32'(COUNT), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
